// File: rtl/gpa_fhdo_spi_rx.sv
`default_nettype none
// ============================================================================
// Module   : gpa_fhdo_spi_rx
// Brief    : SPI slave receiver for 24-bit GPA-FHDO DAC frames. The SPI pins
//            are synchronised into clk and decoded into DAC/sync registers.
//            Optional error counter: define GPA_FHDO_RX_ERRCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gpa_fhdo_spi_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        fhd_clk_i,
  input  logic        fhd_sdi_i,
  input  logic        fhd_csn_i,
`ifdef GPA_FHDO_RX_ERRCNT_EN
  input  logic        err_clr_i,
  output logic [15:0] err_count_o,
`endif
  output logic [15:0] dac0_o,
  output logic [15:0] dac1_o,
  output logic [15:0] dac2_o,
  output logic [15:0] dac3_o,
  output logic [15:0] sync_reg_o,
  output logic [23:0] frame_o,
  output logic        frame_valid_o,
  output logic        frame_err_o,
  output logic        busy_o
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_shift = 2'd1;
  localparam logic [1:0] c_st_check = 2'd2;
  localparam logic [4:0] c_cnt_max  = 5'd25;
  localparam logic [4:0] c_cnt_good = 5'd24;

  logic       r_csn_s1, r_csn_s2, r_csn_d;
  logic       r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic       r_sdi_s1, r_sdi_s2, r_sdi_d;
  logic [1:0] r_settle;
  logic       r_armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_csn_s1  <= 1'b1;
      r_csn_s2  <= 1'b1;
      r_csn_d   <= 1'b1;
      r_sclk_s1 <= 1'b1;
      r_sclk_s2 <= 1'b1;
      r_sclk_d  <= 1'b1;
      r_sdi_s1  <= 1'b0;
      r_sdi_s2  <= 1'b0;
      r_sdi_d   <= 1'b0;
      r_settle  <= 2'b00;
      r_armed   <= 1'b0;
    end else begin
      r_csn_s1  <= fhd_csn_i;
      r_csn_s2  <= r_csn_s1;
      r_csn_d   <= r_csn_s2;
      r_sclk_s1 <= fhd_clk_i;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_sdi_s1  <= fhd_sdi_i;
      r_sdi_s2  <= r_sdi_s1;
      r_sdi_d   <= r_sdi_s2;
      r_settle  <= {r_settle[0], 1'b1};
      // Only arm once the real csn level has been seen high after reset, so a
      // csn held low across reset does not look like a new frame start.
      r_armed   <= r_armed | (r_settle[1] & r_csn_s2);
    end
  end

  logic w_csn_fall, w_csn_rise, w_sclk_fall;

  assign w_csn_fall  = r_armed & r_csn_d & ~r_csn_s2;
  assign w_csn_rise  = ~r_csn_d & r_csn_s2;
  assign w_sclk_fall = r_sclk_d & ~r_sclk_s2 & ~r_csn_s2;

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [23:0] r_shift;
  logic [15:0] r_dac0, r_dac1, r_dac2, r_dac3, r_sync;
  logic [23:0] r_frame;
  logic        r_frame_valid, r_frame_err;
  logic        w_good;

  assign w_good = (r_cnt == c_cnt_good) && (r_shift[23:20] == 4'h0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= c_st_idle;
      r_cnt         <= 5'd0;
      r_shift       <= 24'd0;
      r_dac0        <= 16'd0;
      r_dac1        <= 16'd0;
      r_dac2        <= 16'd0;
      r_dac3        <= 16'd0;
      r_sync        <= 16'd0;
      r_frame       <= 24'd0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (w_csn_fall) begin
            r_state <= c_st_shift;
            r_cnt   <= 5'd0;
            r_shift <= 24'd0;
          end
        end
        c_st_shift: begin
          if (w_csn_rise) begin
            r_state <= c_st_check;
          end else if (w_sclk_fall) begin
            r_shift <= {r_shift[22:0], r_sdi_d};
            if (r_cnt != c_cnt_max) begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        c_st_check: begin
          if (w_good) begin
            r_frame       <= r_shift;
            r_frame_valid <= 1'b1;
            case (r_shift[19:16])
              4'h2:    r_sync <= r_shift[15:0];
              4'h8:    r_dac0 <= r_shift[15:0];
              4'h9:    r_dac1 <= r_shift[15:0];
              4'hA:    r_dac2 <= r_shift[15:0];
              4'hB:    r_dac3 <= r_shift[15:0];
              default: ;
            endcase
          end else begin
            r_frame_err <= 1'b1;
          end
          // A new frame may already be starting while this one is judged.
          if (w_csn_fall) begin
            r_state <= c_st_shift;
            r_cnt   <= 5'd0;
            r_shift <= 24'd0;
          end else begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

`ifdef GPA_FHDO_RX_ERRCNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= 16'd0;
    end else if (err_clr_i) begin
      r_err_cnt <= 16'd0;
    end else if (r_frame_err && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_count_o = r_err_cnt;
`endif

  assign dac0_o        = r_dac0;
  assign dac1_o        = r_dac1;
  assign dac2_o        = r_dac2;
  assign dac3_o        = r_dac3;
  assign sync_reg_o    = r_sync;
  assign frame_o       = r_frame;
  assign frame_valid_o = r_frame_valid;
  assign frame_err_o   = r_frame_err;
  assign busy_o        = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_gpa_fhdo_spi_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpa_fhdo_spi_rx
// Brief    : Scoreboard bench: directed SPI frames push expected register
//            state; a monitor checks it on every valid/error pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpa_fhdo_spi_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        fhd_clk_i, fhd_sdi_i, fhd_csn_i;
  logic [15:0] dac0_o, dac1_o, dac2_o, dac3_o, sync_reg_o;
  logic [23:0] frame_o;
  logic        frame_valid_o, frame_err_o, busy_o;
`ifdef GPA_FHDO_RX_ERRCNT_EN
  logic        err_clr_i;
  logic [15:0] err_count_o;
`endif

  gpa_fhdo_spi_rx dut (
    .clk           (clk),
    .rst           (rst),
    .fhd_clk_i     (fhd_clk_i),
    .fhd_sdi_i     (fhd_sdi_i),
    .fhd_csn_i     (fhd_csn_i),
`ifdef GPA_FHDO_RX_ERRCNT_EN
    .err_clr_i     (err_clr_i),
    .err_count_o   (err_count_o),
`endif
    .dac0_o        (dac0_o),
    .dac1_o        (dac1_o),
    .dac2_o        (dac2_o),
    .dac3_o        (dac3_o),
    .sync_reg_o    (sync_reg_o),
    .frame_o       (frame_o),
    .frame_valid_o (frame_valid_o),
    .frame_err_o   (frame_err_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int last_rise = 0;

  typedef struct {
    logic        is_err;
    logic [23:0] frame;
    logic [15:0] d0, d1, d2, d3, sy;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [23:0] m_frame;
  logic [15:0] m_d0, m_d1, m_d2, m_d3, m_sy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_frame = '0; m_d0 = '0; m_d1 = '0; m_d2 = '0; m_d3 = '0; m_sy = '0;
  endtask

  task automatic push_exp(input logic is_err);
    exp_t x;
    x.is_err = is_err; x.frame = m_frame;
    x.d0 = m_d0; x.d1 = m_d1; x.d2 = m_d2; x.d3 = m_d3; x.sy = m_sy;
    q.push_back(x);
  endtask

  // Apply a well-formed 24-bit frame to the model and queue its expectation.
  task automatic expect_frame(input logic [23:0] d);
    if (d[23:20] != 4'h0) begin
      push_exp(1'b1);
    end else begin
      m_frame = d;
      case (d[19:16])
        4'h2: m_sy = d[15:0];
        4'h8: m_d0 = d[15:0];
        4'h9: m_d1 = d[15:0];
        4'hA: m_d2 = d[15:0];
        4'hB: m_d3 = d[15:0];
        default: ;
      endcase
      push_exp(1'b0);
    end
  endtask

  task automatic sclk_bit(input logic b);
    fhd_clk_i = 1'b1;
    fhd_sdi_i = b;
    wait_cyc(3);
    fhd_clk_i = 1'b0;
    wait_cyc(3);
  endtask

  // Divider 6: sclk high 3 clk, low 3 clk; SDO changes on the rising edge.
  task automatic send(input logic [31:0] data, input int nbits);
    fhd_csn_i = 1'b0;
    wait_cyc(6);
    for (int i = 0; i < nbits; i++) sclk_bit(data[nbits-1-i]);
    wait_cyc(3);
    fhd_csn_i = 1'b1;
    last_rise = cyc;
  endtask

  always @(negedge clk) begin
    if (frame_valid_o || frame_err_o) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: valid=%0b err=%0b with empty queue (cycle %0d)",
                 frame_valid_o, frame_err_o, cyc);
      end else begin
        e = q.pop_front();
        chk("pulse_err",   32'(frame_err_o),   32'(e.is_err));
        chk("pulse_valid", 32'(frame_valid_o), 32'(!e.is_err));
        chk("latency",     32'(cyc - last_rise), 32'd4);
        chk("frame_o",     32'(frame_o),    32'(e.frame));
        chk("dac0_o",      32'(dac0_o),     32'(e.d0));
        chk("dac1_o",      32'(dac1_o),     32'(e.d1));
        chk("dac2_o",      32'(dac2_o),     32'(e.d2));
        chk("dac3_o",      32'(dac3_o),     32'(e.d3));
        chk("sync_reg_o",  32'(sync_reg_o), 32'(e.sy));
      end
    end
  end

  initial begin
    rst = 1'b1; fhd_clk_i = 1'b0; fhd_sdi_i = 1'b0; fhd_csn_i = 1'b1;
`ifdef GPA_FHDO_RX_ERRCNT_EN
    err_clr_i = 1'b0;
`endif
    model_reset();
    wait_cyc(3);
    chk("rst_frame", 32'(frame_o), 32'd0);
    chk("rst_dac0",  32'(dac0_o),  32'd0);
    chk("rst_sync",  32'(sync_reg_o), 32'd0);
    chk("rst_busy",  32'(busy_o),  32'd0);
    chk("rst_pulse", 32'({frame_valid_o, frame_err_o}), 32'd0);
    rst = 1'b0;
    wait_cyc(8);

    // Frame to DAC2
    expect_frame(24'h0A1234); send(32'h0A1234, 24); wait_cyc(12);

    // Back-to-back: csn high for one clk only, next fall lands in CHECK
    expect_frame(24'h020000); send(32'h020000, 24); wait_cyc(1);
    chk("busy_b2b", 32'(busy_o), 32'd1);
    expect_frame(24'h08ABCD); send(32'h08ABCD, 24); wait_cyc(12);

    // Short and long frames are rejected
    push_exp(1'b1); send(32'h0A5678, 23); wait_cyc(12);
    push_exp(1'b1); send(32'h14AC_F1, 25); wait_cyc(12);
`ifdef GPA_FHDO_RX_ERRCNT_EN
    chk("err_count_2", 32'(err_count_o), 32'd2);
`endif

    // Nonzero upper nibble, then an unmapped address
    expect_frame(24'h1B5555); send(32'h1B5555, 24); wait_cyc(12);
    expect_frame(24'h05FFFF); send(32'h05FFFF, 24); wait_cyc(12);
`ifdef GPA_FHDO_RX_ERRCNT_EN
    chk("err_count_3", 32'(err_count_o), 32'd3);
    err_clr_i = 1'b1; wait_cyc(1); err_clr_i = 1'b0; wait_cyc(1);
    chk("err_count_clr", 32'(err_count_o), 32'd0);
`endif

    // Reset mid-frame with csn held low; the rest of that frame is ignored
    fhd_csn_i = 1'b0;
    wait_cyc(6);
    for (int i = 0; i < 12; i++) sclk_bit(1'(24'h09FFFF >> (23 - i)));
    rst = 1'b1; model_reset(); wait_cyc(2); rst = 1'b0;
    for (int i = 0; i < 4; i++) sclk_bit(1'b1);
    wait_cyc(6);
    chk("busy_after_rst", 32'(busy_o), 32'd0);
    chk("dac3_after_rst", 32'(dac3_o), 32'd0);
    fhd_csn_i = 1'b1;
    wait_cyc(10);
    chk("busy_idle", 32'(busy_o), 32'd0);
    expect_frame(24'h090042); send(32'h090042, 24); wait_cyc(12);

    // Stray sclk edges while deselected
    for (int i = 0; i < 8; i++) sclk_bit(1'(i));
    wait_cyc(6);
    chk("busy_stray", 32'(busy_o), 32'd0);
    expect_frame(24'h0B0001); send(32'h0B0001, 24); wait_cyc(12);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
